// File: rtl/column_scramble_addr_gen.sv
// Raster frame-buffer read address generator with key-driven per-row column rotation.
// Optional build macro KEY_ROLL_EN: roll the key register right by one byte at every frame end.
module column_scramble_addr_gen #(
  parameter int H_RES = 640,  // pixels per row, 256..1024
  parameter int V_RES = 480   // rows per frame, <= 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [79:0] column_shift,
  input  logic        key_load,
  input  logic        decrypt,
  input  logic        frame_start,
  input  logic        addr_ready,
  output logic        addr_valid,
  output logic [9:0]  addr_x,
  output logic [9:0]  addr_y,
  output logic        busy,
  output logic        frame_done,
  output logic        key_pending,
  output logic [1:0]  dbg_state
);

  // Handshake: a beat transfers on a rising edge where addr_valid && addr_ready.
  // addr_valid/addr_x/addr_y are flop outputs only and hold until that transfer.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [10:0] H11    = 11'(H_RES);
  localparam logic [9:0]  X_LAST = 10'(H_RES - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_RES - 1);

  state_t      state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [79:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        dec_q, dec_d;
  logic        valid_q, valid_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [3:0]  band_q, band_d;
  logic [9:0]  addr_x_q, addr_x_d;

  logic [9:0]  nx;
  logic [9:0]  ny;
  logic [3:0]  nb;
  logic [79:0] start_key;

  function automatic logic [7:0] key_byte(input logic [79:0] k, input logic [3:0] b);
    logic [6:0] idx;
    idx = {b, 3'b000};
    return k[idx +: 8];
  endfunction

  // Shift is always below H_RES, so one conditional subtract/add replaces a modulo.
  function automatic logic [9:0] scramble(input logic [9:0] x, input logic [7:0] s,
                                          input logic dec);
    logic [10:0] t;
    if (!dec) begin
      t = {1'b0, x} + {3'b000, s};
      if (t >= H11) t = t - H11;
    end else if (x >= {2'b00, s}) begin
      t = {1'b0, x} - {3'b000, s};
    end else begin
      t = {1'b0, x} + H11 - {3'b000, s};
    end
    return t[9:0];
  endfunction

  always_comb begin
    nx = x_q + 10'd1;
    ny = y_q;
    nb = band_q;
    if (x_q == X_LAST) begin
      nx = 10'd0;
      ny = y_q + 10'd1;
      nb = (band_q == 4'd9) ? 4'd0 : band_q + 4'd1;
    end
  end

  // A key loaded together with frame_start applies to the frame it starts.
  assign start_key = key_load ? column_shift : key_q;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    dec_d     = dec_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    band_d    = band_q;
    addr_x_d  = addr_x_q;
    case (state_q)
      ST_IDLE: begin
        if (key_load) key_d = column_shift;
        if (frame_start) begin
          state_d  = ST_RUN;
          dec_d    = decrypt;
          valid_d  = 1'b1;
          x_d      = 10'd0;
          y_d      = 10'd0;
          band_d   = 4'd0;
          addr_x_d = scramble(10'd0, key_byte(start_key, 4'd0), decrypt);
        end
      end
      ST_RUN: begin
        if (key_load) begin
          shadow_d  = column_shift;
          pending_d = 1'b1;
        end
        if (valid_q && addr_ready) begin
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d  = ST_DONE;
            valid_d  = 1'b0;
            x_d      = 10'd0;
            y_d      = 10'd0;
            band_d   = 4'd0;
            addr_x_d = 10'd0;
          end else begin
            x_d      = nx;
            y_d      = ny;
            band_d   = nb;
            addr_x_d = scramble(nx, key_byte(key_q, nb), dec_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (key_load) begin
          key_d     = column_shift;
          pending_d = 1'b0;
        end else if (pending_q) begin
          key_d     = shadow_q;
          pending_d = 1'b0;
        end else begin
`ifdef KEY_ROLL_EN
          key_d = {key_q[7:0], key_q[79:8]};
`else
          key_d = key_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      dec_q     <= 1'b0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      band_q    <= '0;
      addr_x_q  <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      dec_q     <= dec_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      band_q    <= band_d;
      addr_x_q  <= addr_x_d;
    end
  end

  assign addr_valid  = valid_q;
  assign addr_x      = addr_x_q;
  assign addr_y      = y_q;
  assign busy        = (state_q == ST_RUN);
  assign frame_done  = (state_q == ST_DONE);
  assign key_pending = pending_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_column_scramble_addr_gen.sv
// Directed bench for column_scramble_addr_gen on a 640x12 frame (default build, no key roll).
module tb_column_scramble_addr_gen;

  localparam int H    = 640;
  localparam int V    = 12;
  localparam int NPIX = H * V;

  localparam logic [79:0] K1 = {8'd33, 8'd64, 8'd1, 8'd128, 8'd99, 8'd0, 8'd255, 8'd17, 8'd200, 8'd5};
  localparam logic [79:0] K2 = 80'h0a_09_08_07_06_05_04_03_02_01;
  localparam logic [79:0] K3 = 80'hff_ee_dd_cc_bb_aa_99_88_77_10;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] column_shift;
  logic        key_load, decrypt, frame_start, addr_ready;
  logic        addr_valid, busy, frame_done, key_pending;
  logic [9:0]  addr_x, addr_y;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic        load_with_start;
  logic [9:0]  row0_obs[H];
  logic [9:0]  row1_obs[H];
  logic [9:0]  row10_obs[H];
  logic [9:0]  enc_row0[H];
  logic [9:0]  enc_row1[H];

  column_scramble_addr_gen #(.H_RES(H), .V_RES(V)) dut (
    .Clk(clk), .Reset(rst), .column_shift(column_shift), .key_load(key_load),
    .decrypt(decrypt), .frame_start(frame_start), .addr_ready(addr_ready),
    .addr_valid(addr_valid), .addr_x(addr_x), .addr_y(addr_y), .busy(busy),
    .frame_done(frame_done), .key_pending(key_pending), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] model_x(input logic [79:0] k, input logic dec, input int x,
                                         input int y);
    int s;
    s = int'(k[8*(y%10) +: 8]);
    if (dec) return 10'((x - s + H) % H);
    return 10'((x + s) % H);
  endfunction

  task automatic load_key(input logic [79:0] k);
    @(negedge clk);
    column_shift = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    check("idle_load_no_pending", key_pending, 1'b0);
  endtask

  // Drives one frame, checking every presented address against the model.
  task automatic run_frame(input logic dec, input int rdy_pct, input logic [79:0] mkey,
                           input int load_beat, input logic [79:0] nkey, input int stop_beats);
    int beats, cycles, ex, ey;
    bit stalled, load_fired, fs_fired, check_pend;
    logic [19:0] held;
    @(negedge clk);
    frame_start = 1'b1;
    decrypt = dec;
    key_load = load_with_start;
    addr_ready = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    key_load = 1'b0;
    decrypt = ~dec;
    beats = 0; cycles = 0; ex = 0; ey = 0;
    stalled = 0; load_fired = 0; fs_fired = 0; check_pend = 0;
    held = '0;
    while (beats < stop_beats && cycles < 4 * NPIX) begin
      key_load = 1'b0;
      frame_start = 1'b0;
      if (check_pend) begin
        check("key_pending_set", key_pending, 1'b1);
        check_pend = 0;
      end
      if (stalled) check("hold", {addr_y, addr_x}, held);
      check("addr", {addr_valid, addr_y, addr_x}, {1'b1, 10'(ey), model_x(mkey, dec, ex, ey)});
      if (ey == 0) row0_obs[ex] = addr_x;
      if (ey == 1) row1_obs[ex] = addr_x;
      if (ey == 10) row10_obs[ex] = addr_x;
      if (!load_fired && beats == load_beat) begin
        column_shift = nkey;
        key_load = 1'b1;
        load_fired = 1;
        check_pend = 1;
      end
      if (!fs_fired && beats == 300) begin
        frame_start = 1'b1;
        fs_fired = 1;
      end
      addr_ready = ($urandom_range(99) < rdy_pct);
      if (addr_ready) begin
        beats++;
        stalled = 0;
        if (ex == H - 1) begin
          ex = 0;
          ey++;
        end else begin
          ex++;
        end
      end else begin
        stalled = 1;
        held = {addr_y, addr_x};
      end
      cycles++;
      @(negedge clk);
    end
    key_load = 1'b0;
    frame_start = 1'b0;
    if (cycles >= 4 * NPIX) check("frame_timeout", beats, stop_beats);
    if (rdy_pct == 100) check("throughput", cycles, stop_beats);
    if (stop_beats == NPIX) begin
      check("done_state", {frame_done, busy, addr_valid, dbg_state}, {1'b1, 1'b0, 1'b0, 2'd2});
      @(negedge clk);
      check("idle_state", {frame_done, busy, addr_valid, key_pending, dbg_state}, 6'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    column_shift = '0;
    key_load = 1'b0;
    decrypt = 1'b0;
    frame_start = 1'b0;
    addr_ready = 1'b0;
    load_with_start = 1'b0;
    #3;
    check("reset_outputs", {addr_valid, addr_x, addr_y, busy, frame_done, key_pending, dbg_state}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Identity key, continuous ready.
    run_frame(1'b0, 100, 80'd0, -1, 80'd0, NPIX);

    // Encrypt with K1, random back-pressure.
    load_key(K1);
    run_frame(1'b0, 70, K1, -1, 80'd0, NPIX);
    check("enc_r0_x0", row0_obs[0], 10'd5);
    check("enc_r0_x634", row0_obs[634], 10'd639);
    check("enc_r0_x635", row0_obs[635], 10'd0);
    check("enc_r0_x639", row0_obs[639], 10'd4);
    check("enc_r1_x439", row1_obs[439], 10'd639);
    check("enc_r1_x440", row1_obs[440], 10'd0);
    check("enc_r1_x639", row1_obs[639], 10'd199);
    check("enc_r10_x0", row10_obs[0], 10'd5);
    check("enc_r10_x635", row10_obs[635], 10'd0);
    for (int i = 0; i < H; i++) begin
      enc_row0[i] = row0_obs[i];
      enc_row1[i] = row1_obs[i];
    end

    // Decrypt with K1; K2 is loaded mid-frame and must wait for the next frame.
    run_frame(1'b1, 100, K1, 1000, K2, NPIX);
    check("dec_r0_x0", row0_obs[0], 10'd635);
    check("dec_r0_x4", row0_obs[4], 10'd639);
    check("dec_r0_x5", row0_obs[5], 10'd0);
    check("dec_r0_x639", row0_obs[639], 10'd634);
    check("dec_r1_x0", row1_obs[0], 10'd440);
    check("dec_r1_x199", row1_obs[199], 10'd639);
    check("dec_r1_x200", row1_obs[200], 10'd0);
    for (int i = 0; i < H; i++) begin
      check("roundtrip_r0", row0_obs[enc_row0[i]], i);
      check("roundtrip_r1", row1_obs[enc_row1[i]], i);
    end

    // Pending K2 now in effect.
    run_frame(1'b0, 100, K2, -1, 80'd0, NPIX);
    check("k2_r0_x0", row0_obs[0], 10'd1);
    check("k2_r0_x639", row0_obs[639], 10'd0);
    check("k2_r1_x638", row1_obs[638], 10'd0);
    check("k2_r10_x639", row10_obs[639], 10'd0);

    // K3 loaded with frame_start, pending K2 queued, then reset mid-frame.
    load_with_start = 1'b1;
    column_shift = K3;
    run_frame(1'b0, 80, K3, 1000, K2, 5 * H + 17);
    load_with_start = 1'b0;
    check("k3_r0_x0", row0_obs[0], 10'd16);
    check("k3_r0_x623", row0_obs[623], 10'd639);
    check("k3_r0_x624", row0_obs[624], 10'd0);
    check("pre_reset_busy", {busy, key_pending}, 2'b11);
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {addr_valid, addr_x, addr_y, busy, frame_done, key_pending, dbg_state}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Restart after reset: key back to identity, pending key discarded.
    run_frame(1'b0, 100, 80'd0, -1, 80'd0, H + 60);
    check("post_reset_r0_x0", row0_obs[0], 10'd0);
    check("post_reset_r0_x639", row0_obs[639], 10'd639);
    check("post_reset_no_pending", key_pending, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
